// File: rtl/sram_responder.sv
`default_nettype none
// sram_responder: 32-bit word SRAM window with byte-lane writes, one-cycle registered reads,
// sticky out-of-window error capture and accepted read/write counters.
// Revision: 1.0
module sram_responder #(
   parameter int unsigned ADDR_W = 10,
   parameter logic [31:0] BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [3:0]  wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rd_valid,
   output logic        err,
   output logic [31:0] err_addr,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] index;
   logic              in_window;
   logic              is_read;
   logic              is_write;
   logic              unused_addr_lsbs;

   assign index            = addr[ADDR_W+1:2];
   assign in_window        = (addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
   assign is_read          = en && (wen == 4'b0000);
   assign is_write         = en && (wen != 4'b0000);
   assign unused_addr_lsbs = &{1'b0, addr[1:0]};

   // The array has no reset; gating on resetn drops any write sampled while reset is held.
   always_ff @(posedge clk) begin
      if (resetn && is_write && in_window) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (wen[lane]) begin
               mem[index][8*lane +: 8] <= wdata[8*lane +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata    <= 32'h0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
         err_addr <= 32'h0;
         rd_cnt   <= 32'h0;
         wr_cnt   <= 32'h0;
      end else begin
         rd_valid <= is_read;
         if (is_read) begin
            rdata  <= in_window ? mem[index] : 32'h0;
            rd_cnt <= rd_cnt + 32'd1;
         end
         if (is_write) begin
            wr_cnt <= wr_cnt + 32'd1;
         end
         // Only the first offender is kept until reset.
         if (en && !in_window) begin
            err <= 1'b1;
            if (!err) begin
               err_addr <= addr;
            end
         end
      end
   end

endmodule
`default_nettype wire
